adder4_stream_acc: RTL and testbench

Sequential, stream-side counterpart of the four-operand overflow-stopping adder. It accepts 4-bit operands one per handshake, in groups of four, and applies the same stop-on-overflow accumulation rule. It returns one registered {sum, count, ovf} result per group over a valid/ready output handshake. It sits between a serial operand source and any consumer that expects the parallel adder's result format.

---
 rtl/adder4_stream_acc.sv | 155 +++++++++++++++
 tb/tb_adder4_stream_acc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/adder4_stream_acc.sv
`default_nettype none
// ============================================================================
// Module   : adder4_stream_acc
// Purpose  : Serial four-operand accumulator with stop-on-overflow. Takes one
//            W-bit operand per handshake, N operands per group, and returns a
//            registered {sum, count, ovf} result over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module adder4_stream_acc #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic [1:0]   count,
  output logic         ovf,
  output logic [1:0]   op_idx
);

  // Index of the final operand of a group, and the largest non-overflowing sum.
  localparam logic [1:0] c_LAST_IDX = 2'(N - 1);
  localparam logic [W:0] c_MAX_SUM  = {1'b0, {W{1'b1}}};

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  // Per-group working state: wide accumulator, successful-add count, stop flag.
  logic [W:0]   r_acc;
  logic [1:0]   r_adds;
  logic         r_stop;
  logic [1:0]   r_idx;

  // Result registers.
  logic [W-1:0] r_sum;
  logic [1:0]   r_count;
  logic         r_ovf;

  logic         w_accept;
  logic         w_consume;
  logic         w_last;
  logic [W:0]   w_sum_ext;
  logic         w_fits;
  logic [W:0]   w_acc_nxt;
  logic [1:0]   w_adds_nxt;
  logic         w_stop_nxt;

  assign w_last = (r_idx == c_LAST_IDX);

  // State register; an asserted reset discards any partial group or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; in_valid is ignored while a result is pending.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        w_consume = out_ready;
        if (out_ready) begin
          w_state_nxt = S_COLLECT;
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  // Accumulation rule: the first operand seeds acc; later ones add while the sum
  // still fits in W bits, otherwise stop freezes acc/adds for the rest of the group.
  always_comb begin
    w_sum_ext  = r_acc + {1'b0, in_data};
    w_fits     = (w_sum_ext <= c_MAX_SUM);
    w_acc_nxt  = r_acc;
    w_adds_nxt = r_adds;
    w_stop_nxt = r_stop;
    if (r_idx == 2'd0) begin
      w_acc_nxt  = {1'b0, in_data};
      w_adds_nxt = 2'd0;
      w_stop_nxt = 1'b0;
    end else if (!r_stop) begin
      if (w_fits) begin
        w_acc_nxt  = w_sum_ext;
        w_adds_nxt = r_adds + 2'd1;
      end else begin
        w_stop_nxt = 1'b1;
      end
    end
  end

  // Working state and operand index advance only on an accepted operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_adds <= 2'd0;
      r_stop <= 1'b0;
      r_idx  <= 2'd0;
    end else if (w_accept) begin
      r_acc  <= w_acc_nxt;
      r_adds <= w_adds_nxt;
      r_stop <= w_stop_nxt;
      r_idx  <= w_last ? 2'd0 : r_idx + 2'd1;
    end else if (w_consume) begin
      r_idx  <= 2'd0;
    end
  end

  // Result load on the last operand; a lone first operand is never reported as a sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_count <= 2'd0;
      r_ovf   <= 1'b0;
    end else if (w_accept && w_last) begin
      r_sum   <= (w_adds_nxt == 2'd0) ? '0 : w_acc_nxt[W-1:0];
      r_count <= w_adds_nxt;
      r_ovf   <= w_stop_nxt;
    end
  end

  assign sum    = r_sum;
  assign count  = r_count;
  assign ovf    = r_ovf;
  assign op_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_adder4_stream_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder4_stream_acc
// Purpose  : Directed self-checking bench for adder4_stream_acc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder4_stream_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] sum;
  logic [1:0] count;
  logic       ovf;
  logic [1:0] op_idx;

  int n_vec;
  int n_err;

  adder4_stream_acc #(.W(4), .N(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .count     (count),
    .ovf       (ovf),
    .op_idx    (op_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one operand from the falling edge and hold it until accepted.
  task automatic send_op(input logic [3:0] x);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("in_ready_on_send", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  // Idle cycles with garbage data; operand index must not move.
  task automatic idle(input int n, input logic [1:0] exp_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      check_val("op_idx_gap", {30'd0, op_idx}, {30'd0, exp_idx});
    end
  endtask

  // Full group with out_ready held high; result visible right after the 4th accept.
  task automatic run_group(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d,
                           input logic [3:0] e_sum, input logic [1:0] e_cnt,
                           input logic e_ovf);
    out_ready = 1'b1;
    send_op(a);
    send_op(b);
    send_op(c);
    send_op(d);
    check_val("out_valid",  {31'd0, out_valid}, 32'd1);
    check_val("sum",        {28'd0, sum},       {28'd0, e_sum});
    check_val("count",      {30'd0, count},     {30'd0, e_cnt});
    check_val("ovf",        {31'd0, ovf},       {31'd0, e_ovf});
    check_val("in_ready_done", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_val("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check_val("in_ready_back",  {31'd0, in_ready},  32'd1);
    check_val("op_idx_back",    {30'd0, op_idx},    32'd0);
    check_val("sum_kept",       {28'd0, sum},       {28'd0, e_sum});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_sum",       {28'd0, sum},       32'd0);
    check_val("rst_count",     {30'd0, count},     32'd0);
    check_val("rst_ovf",       {31'd0, ovf},       32'd0);
    check_val("rst_op_idx",    {30'd0, op_idx},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Main function and overflow patterns.
    run_group(4'd1,  4'd2, 4'd3, 4'd4, 4'd10, 2'd3, 1'b0);
    run_group(4'd15, 4'd1, 4'd2, 4'd3, 4'd0,  2'd0, 1'b1);
    run_group(4'd14, 4'd3, 4'd5, 4'd6, 4'd0,  2'd0, 1'b1);
    run_group(4'd4,  4'd4, 4'd8, 4'd1, 4'd8,  2'd1, 1'b1);
    run_group(4'd2,  4'd9, 4'd3, 4'd5, 4'd14, 2'd2, 1'b1);
    run_group(4'd3,  4'd3, 4'd3, 4'd3, 4'd12, 2'd3, 1'b0);

    // Boundary: exactly 15 is not an overflow.
    run_group(4'd15, 4'd0, 4'd0, 4'd0, 4'd15, 2'd3, 1'b0);
    run_group(4'd8,  4'd7, 4'd0, 4'd1, 4'd15, 2'd2, 1'b1);

    // Back-pressure with input gaps.
    out_ready = 1'b0;
    send_op(4'd3);
    idle(int'($urandom_range(1, 3)), 2'd1);
    send_op(4'd3);
    idle(int'($urandom_range(1, 3)), 2'd2);
    send_op(4'd3);
    idle(int'($urandom_range(1, 3)), 2'd3);
    send_op(4'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd9;
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check_val("bp_sum",       {28'd0, sum},       32'd12);
      check_val("bp_count",     {30'd0, count},     32'd3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_val("bp_release_ready", {31'd0, in_ready},  32'd1);
    check_val("bp_release_idx",   {30'd0, op_idx},    32'd0);

    // Asynchronous reset mid-group after 7, 8.
    send_op(4'd7);
    send_op(4'd8);
    check_val("pre_rst_idx", {30'd0, op_idx}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("arst_sum",    {28'd0, sum},    32'd0);
    check_val("arst_count",  {30'd0, count},  32'd0);
    check_val("arst_ovf",    {31'd0, ovf},    32'd0);
    check_val("arst_op_idx", {30'd0, op_idx}, 32'd0);
    check_val("arst_valid",  {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_group(4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 2'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
